// File: rtl/aes_ctrl_pkg.sv
// Shared definitions for the AES-128 round sequencer and the cipher wrapper's datapath mux.
// Holds the state and step encodings, the default round count and the round-counter width.
package aes_ctrl_pkg;

  localparam int NR_DEFAULT      = 10;
  localparam int TIMEOUT_DEFAULT = 16;
  localparam int ROUND_W         = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT_ARK,
    ST_SB,
    ST_SR,
    ST_MC,
    ST_ARK,
    ST_FINISH,
    ST_ERR
  } state_e;

  typedef enum logic [2:0] {
    STEP_NONE,
    STEP_SB,
    STEP_SR,
    STEP_MC,
    STEP_ARK
  } step_e;

  // Which step unit a sequencer state drives; INIT_ARK reuses the AddRoundKey unit.
  function automatic step_e state_step(input state_e s);
    step_e r;
    case (s)
      ST_INIT_ARK: r = STEP_ARK;
      ST_SB:       r = STEP_SB;
      ST_SR:       r = STEP_SR;
      ST_MC:       r = STEP_MC;
      ST_ARK:      r = STEP_ARK;
      default:     r = STEP_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_step_timer.sv
// Per-step watchdog: loadable down-counter, reloaded on every state entry,
// decremented while a step is pending; expired_o flags that the budget is spent.
module aes_step_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic run_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CW'(TIMEOUT - 1);
    end else if (run_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= CW'(TIMEOUT - 1);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 round sequencer: walks SB/SR/MC/ARK step units through en/done handshakes.
// Optional inverse-cipher ordering with the AES_DECRYPT_EN macro (adds dir/inv ports).
module aes_round_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int NR      = NR_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
`ifdef AES_DECRYPT_EN
  input  logic               dir,
  output logic               inv,
`endif
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [ROUND_W-1:0] round,
  output logic               in_sel,
  output logic               sb_en,
  input  logic               sb_done,
  output logic               sr_en,
  input  logic               sr_done,
  output logic               mc_en,
  input  logic               mc_done,
  output logic               ark_en,
  input  logic               ark_done
);

  localparam logic [ROUND_W-1:0] LAST_RND = ROUND_W'(NR);

  state_e             state_q, state_d;
  step_e              step_q, step_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic               in_sel_q, in_sel_d;
  logic               err_q, err_d;
  logic               busy_q, done_q;
  logic               sb_en_q, sr_en_q, mc_en_q, ark_en_q;
  logic               accept;
  logic               dec, dec_start;
  logic               step_done;
  logic               tmr_load, tmr_run, tmr_expired;

  assign accept = (state_q == ST_IDLE) && start;

`ifdef AES_DECRYPT_EN
  logic inv_q, inv_d;

  assign inv_d     = accept ? dir : inv_q;
  assign dec       = inv_q;
  assign dec_start = dir;
  assign inv       = inv_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inv_q <= 1'b0;
    end else begin
      inv_q <= inv_d;
    end
  end
`else
  assign dec       = 1'b0;
  assign dec_start = 1'b0;
`endif

  assign step_q = state_step(state_q);
  assign step_d = state_step(state_d);

  // Only the unit owned by the current state may advance the sequence.
  always_comb begin
    step_done = 1'b0;
    case (step_q)
      STEP_SB:  step_done = sb_done;
      STEP_SR:  step_done = sr_done;
      STEP_MC:  step_done = mc_done;
      STEP_ARK: step_done = ark_done;
      default:  step_done = 1'b0;
    endcase
  end

  assign tmr_load = (state_d != state_q);
  assign tmr_run  = (step_q != STEP_NONE);

  aes_step_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_step_timer (
    .clk_i     (clk),
    .rst_ni    (rst),
    .load_i    (tmr_load),
    .run_i     (tmr_run),
    .expired_o (tmr_expired)
  );

  always_comb begin
    state_d  = state_q;
    round_d  = round_q;
    in_sel_d = in_sel_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_INIT_ARK;
          round_d  = dec_start ? LAST_RND : '0;
          in_sel_d = 1'b0;
          err_d    = 1'b0;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      ST_ERR:    state_d = ST_IDLE;
      default: begin
        if (step_done) begin
          case (state_q)
            ST_INIT_ARK: begin
              round_d  = dec ? (LAST_RND - 1'b1) : ROUND_W'(1);
              in_sel_d = 1'b1;
              state_d  = dec ? ST_SR : ST_SB;
            end
            ST_SB: state_d = dec ? ST_ARK : ST_SR;
            // Encrypt skips MixColumns in the final round.
            ST_SR: state_d = dec ? ST_SB : ((round_q < LAST_RND) ? ST_MC : ST_ARK);
            ST_MC: begin
              if (dec) begin
                round_d = round_q - 1'b1;
                state_d = ST_SR;
              end else begin
                state_d = ST_ARK;
              end
            end
            ST_ARK: begin
              if (dec) begin
                state_d = (round_q == '0) ? ST_FINISH : ST_MC;
              end else if (round_q == LAST_RND) begin
                state_d = ST_FINISH;
              end else begin
                round_d = round_q + 1'b1;
                state_d = ST_SB;
              end
            end
            default: ;
          endcase
        end else if (tmr_expired) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      round_q  <= '0;
      in_sel_q <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sb_en_q  <= 1'b0;
      sr_en_q  <= 1'b0;
      mc_en_q  <= 1'b0;
      ark_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      round_q  <= round_d;
      in_sel_q <= in_sel_d;
      err_q    <= err_d;
      busy_q   <= !((state_d == ST_IDLE) || (state_d == ST_ERR));
      done_q   <= (state_d == ST_FINISH);
      sb_en_q  <= (step_d == STEP_SB);
      sr_en_q  <= (step_d == STEP_SR);
      mc_en_q  <= (step_d == STEP_MC);
      ark_en_q <= (step_d == STEP_ARK);
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign round  = round_q;
  assign in_sel = in_sel_q;
  assign sb_en  = sb_en_q;
  assign sr_en  = sr_en_q;
  assign mc_en  = mc_en_q;
  assign ark_en = ark_en_q;

endmodule
